// File: rtl/icache_pkg.sv
// Shared types and widths for the read-only direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 30;
  localparam int MEM_ADDR_W = 28;

  // Word k of a line sits at bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        off);
    return line[{off, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage for the direct-mapped I-cache: async valid clear,
// single write port for line fills, combinational lookup.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter  int NUM_BLOCKS = 8,
  localparam int IDX_W      = $clog2(NUM_BLOCKS),
  localparam int TAG_W      = MEM_ADDR_W - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  output logic             hit_o
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q [NUM_BLOCKS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags are only meaningful behind a set valid bit, so they skip reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache_dm_ro.sv
// Read-only direct-mapped instruction cache with 4-word line fills.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_dm_ro
  import icache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             tag_hit, hit, miss, fill_done;

  assign off      = proc_addr[1:0];
  assign idx      = proc_addr[IDX_W+1:2];
  assign tag      = proc_addr[ADDR_W-1:IDX_W+2];
  // The latched line address already carries {tag, index} of the fill.
  assign fill_idx = maddr_q[IDX_W-1:0];
  assign fill_tag = maddr_q[MEM_ADDR_W-1:IDX_W];

  assign hit       = proc_read & tag_hit;
  assign miss      = proc_read & ~tag_hit;
  assign fill_done = (state_q == FILL) & mem_ready;

  icache_tag_array #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_tags (
    .clk      (clk),
    .rst      (proc_reset),
    .rd_idx_i (idx),
    .rd_tag_i (tag),
    .wr_en_i  (fill_done),
    .wr_idx_i (fill_idx),
    .wr_tag_i (fill_tag),
    .hit_o    (tag_hit)
  );

  logic [LINE_W-1:0] data_q [NUM_BLOCKS];

  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[fill_idx] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= IDLE;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = FILL;
          maddr_d = proc_addr[ADDR_W-1:2];
        end
      end
      FILL: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset forces the core side quiet regardless of proc_read.
        proc_stall = miss & ~proc_reset;
        if (hit) proc_rdata = word_sel(data_q[idx], off);
      end
      FILL: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = maddr_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  logic unused_wr;
  assign unused_wr = ^{proc_write, proc_wdata};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && hit  && hit_cnt_q  != 32'hFFFF_FFFF) hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (state_q == IDLE && miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/icache_dm_ro.md
Name: icache_dm_ro

Overview:
Read-only, direct-mapped instruction cache between the RISC-V core's fetch port and the instruction slow memory (128-bit line interface, `mem_ready` handshake).
- Hits return the instruction combinationally with no stall.
- Misses stall the core, fetch one 4-word line from slow memory, then replay as a hit.
- Instantiated inside the chip top as the I-side cache. `mem_write`/`mem_wdata` exist only for interface symmetry with the D-side.

Parameters:
- NUM_BLOCKS, 8, number of cache lines. Power of two, 2..256. IDX_W = log2(NUM_BLOCKS).
- TAG_W, 28-IDX_W, tag width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  core fetch request.
- proc_write  in  1  ignored (I-side never written); tie 0.
- proc_addr  in  30  word address {tag, index, offset[1:0]}.
- proc_wdata  in  32  ignored.
- proc_rdata  out  32  fetched instruction.
- proc_stall  out  1  core must hold request while high.
- mem_read  out  1  line-fill request.
- mem_write  out  1  constant 0.
- mem_addr  out  28  line address (bits 31:4 of byte address).
- mem_wdata  out  128  constant 0.
- mem_rdata  in  128  returned line; word k at bits [32k+31:32k].
- mem_ready  in  1  one-cycle pulse; mem_rdata valid in that cycle.

Behaviour:
- Storage: per line valid[1], tag[TAG_W], data[128]. Fields: index = proc_addr[IDX_W+1:2], offset = proc_addr[1:0], tag = proc_addr[29:IDX_W+2].
- hit = proc_read & valid[index] & (tag_mem[index]==tag).
- proc_rdata = data[index] word[offset], combinational. Value is don't-care when not hit; drive 0 in IDLE miss and in FILL.
- proc_stall = proc_read & ~hit in IDLE; 1 throughout FILL.
- FSM has two states, IDLE and FILL.
- IDLE:
  - Miss (proc_read & ~hit) goes to FILL next edge. Latch mem_addr_r = proc_addr[29:2].
  - proc_read=0 or hit: stay in IDLE.
- FILL:
  - mem_read=1; mem_addr=mem_addr_r, stable for the whole fill.
  - On mem_ready: write data[idx_r] = mem_rdata, tag_mem[idx_r] = tag_r, valid[idx_r] = 1, then return to IDLE.
  - mem_read drops to 0 in the cycle after mem_ready.
- Miss latency: the miss cycle, then FILL until mem_ready, then one IDLE cycle where the request hits and proc_stall=0. That gives stall cycles = 1 + (memory wait cycles).
- mem_ready outside FILL is ignored, with no state change.
- proc_addr change during FILL: ignored; the fill completes for the latched line. The new address is evaluated in IDLE afterwards.
- proc_read dropped during FILL: the fill still completes and the line is installed.
- Reset (async, any state):
  - state=IDLE; all valid=0; mem_read=0; mem_addr=0; proc_stall=0 (proc_read irrelevant while reset asserted).
  - Tags/data need no reset.
  - An in-flight fill is abandoned. The memory-side response after reset is ignored per the IDLE rule.
- Replacement: direct-mapped, overwrite unconditionally; no dirty state.
- mem_write=0 and mem_wdata=0 always.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - hit_cnt increments each IDLE cycle with proc_read & hit.
  - miss_cnt increments once per IDLE→FILL transition.
  - Both saturate at 32'hFFFF_FFFF. Not incremented during reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package icache_pkg:
  - state encoding (IDLE=1'b0, FILL=1'b1);
  - LINE_W=128, WORD_W=32, ADDR_W=30, MEM_ADDR_W=28;
  - function for word select from a line.
- One sub-module, icache_tag_array: valid/tag storage, async clear of valid, compare output hit. The data array stays in the top.

Test Plan:
- Cold miss: reset, proc_read=1, proc_addr=30'h0000_0000. Expect proc_stall=1 and mem_read=1 with mem_addr=28'h0. Memory returns 128'h00000013_00A00093_00500113_00000093 after 4 cycles. The next cycle has proc_stall=0 and proc_rdata=32'h00000093; offsets 1..3 then hit with 0 stall and return 00500113, 00A00093, 00000013.
- Conflict: with NUM_BLOCKS=8, fill addr 30'h0, then fetch 30'h20 (same index 0, different tag). Expect a miss with mem_addr=28'h8. Refetching 30'h0 then misses again.
- Address change mid-fill: miss on 30'h4, switch proc_addr to 30'h8 during FILL. mem_addr stays 28'h1 until mem_ready. 30'h8 then misses and issues mem_addr=28'h2.
- Reset mid-fill: assert proc_reset during FILL. mem_read=0 immediately and valid cleared; a late mem_ready is ignored. A fetch of the previously hit address 30'h0 misses again.
- Stray mem_ready in IDLE with proc_read=0: no state change, no line written, mem_read stays 0.
- ICACHE_STATS_EN: run the cold-miss scenario (4 words of one line). Expect miss_cnt=1 and hit_cnt=4. Preload hit_cnt near saturation via force to check it holds at FFFF_FFFF.
